// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register with valid/ready handshake and a one-entry skid buffer.
// id_ready is decoded from the state register only, so there is no combinational ready path.
//
// state | meaning
// EMPTY | main and skid invalid
// ONE   | main valid, drives ex_*
// TWO   | main and skid valid, decode is back-pressured
module id_ex_skid_reg #(
   parameter int OP_W   = 8,
   parameter int WORD_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [OP_W-1:0]   id_exOp,
   input  logic [WORD_W-1:0] id_src1,
   input  logic [WORD_W-1:0] id_src2,
   input  logic [REG_AW-1:0] id_regDest,
   input  logic              id_writeReg,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [OP_W-1:0]   ex_exOp,
   output logic [WORD_W-1:0] ex_src1,
   output logic [WORD_W-1:0] ex_src2,
   output logic [REG_AW-1:0] ex_regDest,
   output logic              ex_writeReg,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int PW = OP_W + 2*WORD_W + REG_AW + 1;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     main_q, main_d;
   logic [PW-1:0]     skid_q, skid_d;
   logic [PW-1:0]     id_pl;
   logic [CNT_W-1:0]  stall_q;
   logic              wr_stored;
   logic              accept;
   logic              pop;

   assign id_pl    = {id_exOp, id_src1, id_src2, id_regDest, id_writeReg};
   assign id_ready = (state_q != TWO);
   assign ex_valid = (state_q != EMPTY);
   assign accept   = id_valid & id_ready;
   assign pop      = ex_valid & ex_ready;

   assign {ex_exOp, ex_src1, ex_src2, ex_regDest, wr_stored} = main_q;
   // A bubble (including the cycle after a flush) must never write the register file.
   assign ex_writeReg = wr_stored & ex_valid;
   assign stall_cnt   = stall_q;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d = ONE;
                  main_d  = id_pl;
               end
            end
            ONE: begin
               if (accept && pop) begin
                  main_d = id_pl;
               end else if (accept) begin
                  state_d = TWO;
                  skid_d  = id_pl;
               end else if (pop) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               if (pop) begin
                  state_d = ONE;
                  main_d  = skid_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   // Saturating count of stalled cycles; only reset clears it, flush does not.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else if (ex_valid && !ex_ready && (stall_q != {CNT_W{1'b1}})) begin
         stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Directed and randomised checks for id_ex_skid_reg; a second instance with a
// 4-bit stall counter covers saturation.
module tb_id_ex_skid_reg;

   localparam int PW = 8 + 32 + 32 + 5 + 1;

   logic        clk = 1'b0;
   logic        rst, flush, id_valid, ex_ready;
   logic [7:0]  id_exOp;
   logic [31:0] id_src1, id_src2;
   logic [4:0]  id_regDest;
   logic        id_writeReg;

   logic        id_ready, ex_valid, ex_writeReg;
   logic [7:0]  ex_exOp;
   logic [31:0] ex_src1, ex_src2;
   logic [4:0]  ex_regDest;
   logic [15:0] stall_cnt;

   logic        s_id_ready, s_ex_valid, s_ex_writeReg;
   logic [7:0]  s_ex_exOp;
   logic [31:0] s_ex_src1, s_ex_src2;
   logic [4:0]  s_ex_regDest;
   logic [3:0]  s_stall_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   id_ex_skid_reg dut (
      .clk(clk), .rst(rst), .flush(flush),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_exOp(id_exOp), .id_src1(id_src1), .id_src2(id_src2),
      .id_regDest(id_regDest), .id_writeReg(id_writeReg),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_exOp(ex_exOp), .ex_src1(ex_src1), .ex_src2(ex_src2),
      .ex_regDest(ex_regDest), .ex_writeReg(ex_writeReg),
      .stall_cnt(stall_cnt)
   );

   id_ex_skid_reg #(.CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .flush(flush),
      .id_valid(id_valid), .id_ready(s_id_ready),
      .id_exOp(id_exOp), .id_src1(id_src1), .id_src2(id_src2),
      .id_regDest(id_regDest), .id_writeReg(id_writeReg),
      .ex_valid(s_ex_valid), .ex_ready(ex_ready),
      .ex_exOp(s_ex_exOp), .ex_src1(s_ex_src1), .ex_src2(s_ex_src2),
      .ex_regDest(s_ex_regDest), .ex_writeReg(s_ex_writeReg),
      .stall_cnt(s_stall_cnt)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] op, input logic [31:0] s1,
                        input logic [31:0] s2, input logic [4:0] rd, input logic wr);
      id_valid    = v;
      id_exOp     = op;
      id_src1     = s1;
      id_src2     = s2;
      id_regDest  = rd;
      id_writeReg = wr;
   endtask

   function automatic logic [PW-1:0] ex_bus();
      return {ex_exOp, ex_src1, ex_src2, ex_regDest, ex_writeReg};
   endfunction

   logic [PW-1:0] sb[$];
   logic [PW-1:0] pl, prev_bus;
   logic          acc, pp, prev_stall;
   int            n_push, n_pop;

   initial begin
      rst = 1'b1; flush = 1'b0; ex_ready = 1'b0;
      drive(1'b1, 8'hC3, 32'hDEADBEEF, 32'h12345678, 5'd17, 1'b1);
      tick();
      tick();
      chk("rst_ex_valid", ex_valid, 0);
      chk("rst_id_ready", id_ready, 1);
      chk("rst_payload", ex_bus(), 0);
      chk("rst_stall", stall_cnt, 0);

      // Streaming
      rst = 1'b0; ex_ready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         drive(1'b1, 8'(i), 32'h1000 + 32'(i), 32'(i), 5'(i), 1'b1);
         tick();
         chk("stream_valid", ex_valid, 1);
         chk("stream_op", ex_exOp, 128'(i));
         chk("stream_src1", ex_src1, 32'h1000 + 32'(i));
         chk("stream_ready", id_ready, 1);
      end
      drive(1'b0, 8'h00, 32'h0, 32'h0, 5'd0, 1'b0);
      tick();
      chk("stream_drained", ex_valid, 0);
      chk("stream_wr_bubble", ex_writeReg, 0);

      // Back-pressure
      ex_ready = 1'b0;
      drive(1'b1, 8'hA1, 32'hAAAA0001, 32'hAAAA0002, 5'd3, 1'b1);
      tick();
      chk("bp_A_op", ex_exOp, 8'hA1);
      chk("bp_stall0", stall_cnt, 0);
      drive(1'b1, 8'hB2, 32'hBBBB0001, 32'hBBBB0002, 5'd4, 1'b0);
      tick();
      chk("bp_full_ready", id_ready, 0);
      chk("bp_hold_A", ex_bus(), {8'hA1, 32'hAAAA0001, 32'hAAAA0002, 5'd3, 1'b1});
      chk("bp_stall1", stall_cnt, 1);
      drive(1'b0, 8'h00, 32'h0, 32'h0, 5'd0, 1'b0);
      tick();
      chk("bp_stall2", stall_cnt, 2);
      tick();
      chk("bp_stall3", stall_cnt, 3);
      chk("bp_hold_A2", ex_bus(), {8'hA1, 32'hAAAA0001, 32'hAAAA0002, 5'd3, 1'b1});
      ex_ready = 1'b1;
      tick();
      chk("drain_B", ex_bus(), {8'hB2, 32'hBBBB0001, 32'hBBBB0002, 5'd4, 1'b0});
      chk("drain_ready", id_ready, 1);
      chk("drain_stall_kept", stall_cnt, 3);
      tick();
      chk("drain_empty", ex_valid, 0);

      // Flush from TWO with an incoming entry
      ex_ready = 1'b0;
      drive(1'b1, 8'hD4, 32'hD, 32'hD, 5'd5, 1'b1);
      tick();
      drive(1'b1, 8'hE5, 32'hE, 32'hE, 5'd6, 1'b1);
      tick();
      chk("fl_full", id_ready, 0);
      drive(1'b1, 8'hC6, 32'hC, 32'hC, 5'd7, 1'b1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(1'b0, 8'h00, 32'h0, 32'h0, 5'd0, 1'b0);
      chk("fl_valid", ex_valid, 0);
      chk("fl_wr", ex_writeReg, 0);
      chk("fl_ready", id_ready, 1);
      chk("fl_stall_kept", stall_cnt, 5);
      ex_ready = 1'b1;
      tick();
      chk("fl_no_ghost", ex_valid, 0);

      // Saturation on the 4-bit counter instance
      rst = 1'b1;
      tick();
      rst = 1'b0; ex_ready = 1'b0;
      drive(1'b1, 8'h77, 32'h7, 32'h7, 5'd7, 1'b1);
      tick();
      drive(1'b0, 8'h00, 32'h0, 32'h0, 5'd0, 1'b0);
      for (int i = 0; i < 20; i++) tick();
      chk("sat_small", s_stall_cnt, 15);
      chk("sat_wide", stall_cnt, 20);
      tick();
      chk("sat_small_hold", s_stall_cnt, 15);

      // Random push/pop against a queue model
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      n_push = 0; n_pop = 0; prev_stall = 1'b0; prev_bus = '0;
      for (int c = 0; c < 10000; c++) begin
         chk("rnd_valid", ex_valid, (sb.size() != 0));
         chk("rnd_ready", id_ready, (sb.size() != 2));
         if (sb.size() != 0) chk("rnd_order", ex_bus(), sb[0]);
         if (prev_stall) chk("rnd_stable", ex_bus(), prev_bus);
         pl = PW'({$urandom, $urandom, $urandom});
         drive($urandom_range(0, 1) == 1, pl[77:70], pl[69:38], pl[37:6], pl[5:1], pl[0]);
         ex_ready = ($urandom_range(0, 1) == 1);
         acc = id_valid && (sb.size() != 2);
         pp  = (sb.size() != 0) && ex_ready;
         prev_stall = (sb.size() != 0) && !ex_ready;
         prev_bus   = ex_bus();
         tick();
         if (pp) begin
            void'(sb.pop_front());
            n_pop++;
         end
         if (acc) begin
            sb.push_back({id_exOp, id_src1, id_src2, id_regDest, id_writeReg});
            n_push++;
         end
      end
      drive(1'b0, 8'h00, 32'h0, 32'h0, 5'd0, 1'b0);
      ex_ready = 1'b1;
      for (int i = 0; i < 4 && sb.size() != 0; i++) begin
         chk("rnd_tail", ex_bus(), sb[0]);
         void'(sb.pop_front());
         n_pop++;
         tick();
      end
      chk("rnd_empty", ex_valid, 0);
      chk("rnd_count", n_pop, n_push);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
